// File: rtl/uart_tx.sv
// uart_tx: byte-oriented UART transmitter with a small input FIFO.
// Frames are 8N1; defining UART_TX_PARITY_EN adds an even-parity bit
// between data bit 7 and the stop bit (8E1, 11-bit frames).
module uart_tx #(
  parameter int unsigned CLOCKS_PER_BAUD = 0,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx,
  output logic       busy_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 16;
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] FULL_CNT    = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Frame state
  state_t        state_q, state_d;
  logic          tx_d;
  logic [7:0]    shift_q, shift_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          start_frame;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign ready_o = (count_q != FULL_CNT);
  assign push    = valid_i && ready_o;
  assign head    = mem[rd_ptr_q];
  assign busy_o  = (state_q != S_IDLE) || (count_q != '0);

  // FIFO data array; no reset needed, validity tracked by count_q
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_i;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame state register; reset forces the line high immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tx      <= 1'b1;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx      <= tx_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, next line value and FIFO pop decision
  always_comb begin
    state_d     = state_q;
    tx_d        = tx;
    shift_d     = shift_q;
    baud_d      = (baud_q == '0) ? baud_q : baud_q - BW'(1);
    bit_d       = bit_q;
    pop         = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) start_frame = 1'b1;
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baud_q == '0) begin
          if (count_q != '0) begin
            start_frame = 1'b1;
          end else begin
            baud_d  = '0;
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    // Load the FIFO head and begin a start bit (from idle or straight after a stop bit)
    if (start_frame) begin
      pop     = 1'b1;
      shift_d = head;
      tx_d    = 1'b0;
      baud_d  = BAUD_RELOAD;
      state_d = S_START;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

endmodule
